// File: rtl/cmd_tree_issue_ctrl.sv
// Issue controller in front of the 1-to-N command tree: buffers host commands,
// streams one beat per cycle into the tree, and flags when the tree has drained.
module cmd_tree_issue_ctrl #(
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_WIDTH    = 4,
  parameter int TREE_LATENCY    = 4
) (
  input  logic                            CLK,
  input  logic                            rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [NUM_OUTPUT_DATA-1:0]      i_mask,
  input  logic [REPEAT_WIDTH-1:0]         i_repeat,
  input  logic                            i_flush,
  output logic                            o_en,
  output logic [NUM_OUTPUT_DATA-1:0]      o_cmd,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (TREE_LATENCY > 2) ? $clog2(TREE_LATENCY) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(TREE_LATENCY - 1);

  typedef struct packed {
    logic [NUM_OUTPUT_DATA-1:0] mask;
    logic [REPEAT_WIDTH-1:0]    rep;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  cmd_t                       mem [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count, count_nxt;
  logic                       full_q;
  logic                       empty, push, pop, done_nxt;
  cmd_t                       head;

  state_t                     state;
  logic [NUM_OUTPUT_DATA-1:0] mask_reg;
  logic [REPEAT_WIDTH-1:0]    beat_cnt;
  logic [DW-1:0]              drain_cnt;

  assign empty        = (count == '0);
  assign o_ready      = ~full_q & ~i_flush;
  assign push         = i_valid & o_ready;
  assign head         = mem[rd_ptr];
  assign o_fifo_count = count;
  assign o_busy       = (state != IDLE) | ~empty;

  // Pops are decided by the FSM; a flush suppresses them.
  always_comb begin
    pop = 1'b0;
    if (!i_flush && !empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        ISSUE:   pop = (beat_cnt == '0);
        DRAIN:   pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  // o_done is registered, so it is decided one cycle early: the last drain
  // cycle can only end empty if nothing is pushed or flushed the cycle before.
  assign done_nxt = (state == DRAIN) && (drain_cnt == DW'(1)) && empty &&
                    !push && !i_flush;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{mask: i_mask, rep: i_repeat};
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_reg  <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      o_en      <= 1'b0;
      o_cmd     <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= done_nxt;
      if (i_flush) begin
        beat_cnt <= '0;
        o_en     <= 1'b0;
        o_cmd    <= '0;
        if (state != IDLE) begin
          state     <= DRAIN;
          drain_cnt <= DRAIN_INIT;
        end
      end else if (pop) begin
        // Reload from any state; back-to-back commands issue without a bubble.
        state    <= ISSUE;
        mask_reg <= head.mask;
        beat_cnt <= head.rep;
        o_en     <= 1'b1;
        o_cmd    <= head.mask;
      end else begin
        case (state)
          ISSUE: begin
            if (beat_cnt != '0) begin
              beat_cnt <= beat_cnt - REPEAT_WIDTH'(1);
              o_en     <= 1'b1;
              o_cmd    <= mask_reg;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_INIT;
              o_en      <= 1'b0;
              o_cmd     <= '0;
            end
          end
          DRAIN: begin
            o_en  <= 1'b0;
            o_cmd <= '0;
            if (drain_cnt == '0) state <= IDLE;
            else                 drain_cnt <= drain_cnt - DW'(1);
          end
          default: begin
            o_en  <= 1'b0;
            o_cmd <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/cmd_tree_issue_ctrl.md
# cmd_tree_issue_ctrl

Command issue controller that sits directly upstream of the 1-to-8 sequential command binary tree. It accepts 8-bit destination masks with a repeat count from the host side over a valid/ready handshake and buffers them in a small FIFO. It drives the tree's enable and command inputs one beat per cycle. It tracks the tree's fixed pipeline latency so it can flag when the last issued beat has reached the tree leaves.

## Interface
- NUM_OUTPUT_DATA, 8, width of the command mask (one bit per tree leaf); power of 2
- FIFO_DEPTH, 4, command entries buffered; power of 2, ≥2
- REPEAT_WIDTH, 4, width of repeat field
- TREE_LATENCY, 4, clock edges from tree input sample to tree leaf output ($clog2(NUM_OUTPUT_DATA)+1)

Ports:
- CLK  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  host command valid
- o_ready  out  1  FIFO can accept; equals ~full & ~i_flush
- i_mask  in  NUM_OUTPUT_DATA  destination mask, bit k drives leaf k
- i_repeat  in  REPEAT_WIDTH  beats to issue minus one (0 → 1 beat, 15 → 16 beats)
- i_flush  in  1  synchronous abort: clear FIFO and current command
- o_en  out  1  tree enable (registered)
- o_cmd  out  NUM_OUTPUT_DATA  tree command (registered)
- o_busy  out  1  state != IDLE or FIFO non-empty
- o_done  out  1  one-cycle pulse when last beat exits the tree and nothing is pending
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset values: o_en=0, o_cmd=0, o_done=0, o_busy=0, o_fifo_count=0, state=IDLE. FIFO pointers, beat counter, and drain counter are all 0.
- Push: i_valid & o_ready at a rising edge writes {i_mask, i_repeat}. Push while full is dropped, and o_ready is low in that case.
- Pop happens only inside the FSM. A push and a pop in the same edge leave the count unchanged. When full, a push is not accepted even if a pop occurs that edge.
- FSM, state IDLE:
  - o_en=0.
  - If the FIFO is non-empty: pop the head, load mask_reg and beat_cnt=repeat, and go to ISSUE.
- FSM, state ISSUE:
  - o_en=1 and o_cmd=mask_reg for each beat.
  - While beat_cnt>0: decrement it.
  - On the last beat (beat_cnt==0), if the FIFO is non-empty: pop and reload in the same edge. There is no bubble between commands.
  - On the last beat, if the FIFO is empty: go to DRAIN with drain_cnt=TREE_LATENCY-1.
- FSM, state DRAIN:
  - o_en=0 and o_cmd=0.
  - If the FIFO is non-empty: pop, reload, and go to ISSUE. No o_done is produced for this drain.
  - Else, if drain_cnt==0: pulse o_done and go to IDLE.
  - Else: decrement drain_cnt.
- o_cmd is forced to 0 whenever o_en=0.
- A zero mask is legal and is issued as normal beats.
- i_flush (has priority over every other event):
  - Next edge: FIFO emptied, beat_cnt cleared, o_en=0.
  - ISSUE or DRAIN goes to DRAIN with drain_cnt=TREE_LATENCY-1, so o_done still marks the tree being empty.
  - IDLE stays IDLE.
  - A push in the flush cycle is rejected.
- Reset asserted mid-operation returns all state to the reset values immediately, with no o_done pulse.

## Timing
- A command accepted at edge E0 is popped at edge E1. Its first o_en beat is the cycle after E1, i.e. o_en first samples high by the tree at E2.
- Beats: repeat+1 consecutive cycles of o_en=1.
- Back-to-back commands issue with zero idle cycles between them.
- Tree leaf output for a beat sampled at edge Et appears after edge Et+TREE_LATENCY-1. The leaf value is valid during the cycle that ends at Et+TREE_LATENCY.
- o_done is high in the cycle in which the last beat's mask is on the tree outputs, TREE_LATENCY cycles after the last o_en=1 cycle.
- o_ready combinationally depends only on the registered full flag and i_flush.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-ISSUE.
  - Required response: o_en=0, o_cmd=0, o_fifo_count=0, o_ready=1 immediately; no o_done.
- Single command:
  - Stimulus: push mask=8'hA5, repeat=2.
  - Required response: o_en high for exactly 3 cycles starting 2 edges after accept, o_cmd=8'hA5.
  - Tree leaves 0,2,5,7 are high for 3 cycles.
  - o_done pulses once, 4 cycles after the last o_en.
- Back-to-back:
  - Stimulus: push 8'h01/r0, 8'h80/r1, 8'hFF/r0 on consecutive cycles.
  - Required response: o_cmd sequence 01,80,80,FF with no gaps.
  - A single o_done follows the FF beat.
- Full FIFO:
  - Stimulus: hold i_valid for 6 cycles with repeat=15.
  - Required response: o_fifo_count never exceeds 4, and o_ready drops when full.
  - Exactly the accepted entries are issued, 16 beats each, in order.
- Flush:
  - Stimulus: flush on the 3rd beat of a repeat=7 command with 2 queued.
  - Required response: o_en=0 next cycle, o_fifo_count=0.
  - o_done fires 4 cycles later, and the queued commands are never issued.
- Drain interrupt:
  - Stimulus: push a new command 2 cycles into DRAIN.
  - Required response: the new command issues and no o_done appears until its own drain completes.
